writeback_stage: RTL

//  MEM/WB stage of the RISC-V pipeline; sole producer of the register file write port (WriteReg/WriteData/RegWrite).

---
 rtl/riscv_wb_pkg.sv | 26 ++
 rtl/load_extend.sv | 42 ++++
 rtl/writeback_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared widths, load-size encodings, pending-buffer state and payload types for the MEM/WB stage.
package riscv_wb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RF_AW = 6;
  localparam int unsigned RD_W  = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } lu_entry_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a raw doubleword and sign- or zero-extends it.
module load_extend
  import riscv_wb_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] ext_c
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] word_sh;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [31:0]     w;

  // Lane select: shift the addressed field down to bit 0.
  always_comb begin
    byte_sh = raw >> {addr_lo, 3'b000};
    half_sh = raw >> {addr_lo[2:1], 4'b0000};
    word_sh = raw >> {addr_lo[2], 5'b00000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    w = word_sh[31:0];
  end

  always_comb begin
    ext_c = '0;
    case (funct3)
      F3_LB:   ext_c = {{(XLEN-8){b[7]}}, b};
      F3_LH:   ext_c = {{(XLEN-16){h[15]}}, h};
      F3_LW:   ext_c = {{(XLEN-32){w[31]}}, w};
      F3_LD:   ext_c = raw;
      F3_LBU:  ext_c = XLEN'(b);
      F3_LHU:  ext_c = XLEN'(h);
      F3_LWU:  ext_c = XLEN'(w);
      default: ext_c = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: registers the retiring result onto the register file write port and merges
// long-latency unit results through a one-entry pending buffer. Optional: WB_BYPASS_EN.
module writeback_stage
  import riscv_wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [RD_W-1:0]   mem_rd,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_funct3,
  input  logic [2:0]        mem_addr_lo,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic              lu_valid,
  input  logic [RD_W-1:0]   lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  output logic              pend_busy,
  output logic [RD_W-1:0]   pend_rd,
  output logic [RF_AW-1:0]  rf_write_reg,
  output logic [XLEN-1:0]   rf_write_data,
  output logic              rf_regwrite
`ifdef WB_BYPASS_EN
  ,
  input  logic [RD_W-1:0]   byp_rs1,
  input  logic [RD_W-1:0]   byp_rs2,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  output logic [XLEN-1:0]   byp_data1,
  output logic [XLEN-1:0]   byp_data2
`endif
);

  pend_state_e      state, state_n;
  lu_entry_t        pend, pend_n;
  logic             we_n;
  logic [RF_AW-1:0] reg_n;
  logic [XLEN-1:0]  data_n;
  logic             pw;
  logic             lu_take;
  logic [XLEN-1:0]  load_ext;
  logic [XLEN-1:0]  mem_data;

  load_extend u_load_extend (
    .raw     (mem_load_data),
    .funct3  (mem_funct3),
    .addr_lo (mem_addr_lo),
    .ext_c   (load_ext)
  );

  assign pw       = mem_valid && mem_regwrite && (mem_rd != '0);
  assign lu_take  = lu_valid && lu_ready && (lu_rd != '0);
  assign mem_data = mem_is_load ? load_ext : mem_alu_result;

  // Next-state and output-slot arbitration; a pipeline write always owns the slot.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    we_n    = 1'b0;
    reg_n   = rf_write_reg;
    data_n  = rf_write_data;

    if (pw) begin
      we_n   = 1'b1;
      reg_n  = RF_AW'(mem_rd);
      data_n = mem_data;
    end

    case (state)
      PEND_EMPTY: begin
        if (lu_take) begin
          if (pw) begin
            pend_n  = '{rd: lu_rd, data: lu_data};
            state_n = PEND_FULL;
          end else begin
            we_n   = 1'b1;
            reg_n  = RF_AW'(lu_rd);
            data_n = lu_data;
          end
        end
      end
      PEND_FULL: begin
        if (!pw) begin
          we_n    = 1'b1;
          reg_n   = RF_AW'(pend.rd);
          data_n  = pend.data;
          pend_n  = '0;
          state_n = PEND_EMPTY;
        end else if (mem_rd == pend.rd) begin
          // Younger pipeline write to the same rd makes the pending value dead.
          pend_n  = '0;
          state_n = PEND_EMPTY;
        end
      end
      default: begin
        pend_n  = '0;
        state_n = PEND_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= PEND_EMPTY;
      pend          <= '0;
      rf_regwrite   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      lu_ready      <= 1'b1;
      pend_busy     <= 1'b0;
      pend_rd       <= '0;
    end else begin
      state         <= state_n;
      pend          <= pend_n;
      rf_regwrite   <= we_n;
      rf_write_reg  <= reg_n;
      rf_write_data <= data_n;
      lu_ready      <= (state_n == PEND_EMPTY);
      pend_busy     <= (state_n == PEND_FULL);
      pend_rd       <= pend_n.rd;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write landing this cycle to same-cycle register file readers.
  always_comb begin
    byp_data1 = rf_data1;
    byp_data2 = rf_data2;
    if (rf_regwrite && (byp_rs1 != '0) && (rf_write_reg == RF_AW'(byp_rs1)))
      byp_data1 = rf_write_data;
    if (rf_regwrite && (byp_rs2 != '0) && (rf_write_reg == RF_AW'(byp_rs2)))
      byp_data2 = rf_write_data;
  end
`endif

endmodule
